// File: rtl/dcache_write_buffer_pkg.sv
// dcache_write_buffer_pkg: shared constants and the drain FSM encoding for the DCache write-back buffer.
// Line geometry: 8 x 32-bit words per line; the tag is address bits [31:5].
// No logic lives here; both the top and the CAM import it.
package dcache_write_buffer_pkg;

  localparam int WB_DEPTH   = 4;
  localparam int WB_LINE_W  = 256;
  localparam int WB_ADDR_W  = 32;
  localparam int WB_TAG_LSB = 5;

  localparam logic VALID   = 1'b1;
  localparam logic INVALID = 1'b0;

  typedef enum logic {
    STATE_WB_IDLE  = 1'b0,
    STATE_WB_DRAIN = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_addr_cam.sv
// wb_addr_cam: DEPTH-way tag comparator returning a one-hot (or multi-hot) match vector.
// Purely combinational, zero latency; no flow control.
// Only valid entries can match; priority selection is left to the caller.
module wb_addr_cam
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int TAG_W = WB_ADDR_W - WB_TAG_LSB
) (
  input  logic [DEPTH-1:0]       valid_i,
  input  logic [DEPTH*TAG_W-1:0] tags_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic [DEPTH-1:0]       match_o
);

  // Compare the probe tag against every stored tag in parallel.
  always_comb begin
    match_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_o[i] = valid_i[i] && (tags_i[i*TAG_W +: TAG_W] == tag_i);
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: circular FIFO of evicted dirty lines, drained one line at a time to the AXI cached-write port.
// Push to empty flag: 1 cycle; push to axi_data_wen_o: 2 cycles; lookup is combinational.
// Optional macro WB_FORWARD_EN adds lookup forwarding and in-place merge; a non-merging push when full is dropped.
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int LINE_W = WB_LINE_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_push_i,
  input  logic [ADDR_W-1:0] wb_push_addr_i,
  input  logic [LINE_W-1:0] wb_push_data_i,
  output logic              wb_full_o,
  output logic              wb_empty_o,
  input  logic [ADDR_W-1:0] wb_lookup_addr_i,
  output logic              wb_hit_o,
  output logic [LINE_W-1:0] wb_hit_data_o,
  output logic              axi_data_wen_o,
  output logic [ADDR_W-1:0] axi_data_awaddr_o,
  output logic [LINE_W-1:0] axi_data_wdata_o,
  input  logic              axi_data_bvalid_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - WB_TAG_LSB;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [LINE_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  wb_state_e         state_q, state_d;

  logic [TAG_W-1:0]  push_tag;
  logic [DEPTH-1:0]  merge_vec;
  logic              push_merge;
  logic              push_append;
  logic              pop;

  assign push_tag    = wb_push_addr_i[ADDR_W-1:WB_TAG_LSB];
  assign push_merge  = wb_push_i && (merge_vec != '0);
  assign push_append = wb_push_i && !push_merge && (count_q != CNT_FULL);
  assign pop         = (state_q == STATE_WB_DRAIN) && axi_data_bvalid_i;

`ifdef WB_FORWARD_EN
  logic [DEPTH*TAG_W-1:0] tags_flat;
  logic [DEPTH-1:0]       push_match;
  logic [DEPTH-1:0]       lookup_match;
  logic [DEPTH-1:0]       lookup_young;
  logic [DEPTH-1:0]       lookup_sel;
  logic [DEPTH-1:0]       head_onehot;
  logic                   unused_fwd;

  // Flatten the tag array for the comparators.
  always_comb begin
    tags_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tags_flat[i*TAG_W +: TAG_W] = tag_q[i];
    end
  end

  wb_addr_cam #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_push_cam (
    .valid_i (valid_q),
    .tags_i  (tags_flat),
    .tag_i   (push_tag),
    .match_o (push_match)
  );

  wb_addr_cam #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_lookup_cam (
    .valid_i (valid_q),
    .tags_i  (tags_flat),
    .tag_i   (wb_lookup_addr_i[ADDR_W-1:WB_TAG_LSB]),
    .match_o (lookup_match)
  );

  assign head_onehot = DEPTH'(1) << head_q;

  // The line on the bus must stay stable, so the draining head never takes a merge.
  assign merge_vec = push_match & ~((state_q == STATE_WB_DRAIN) ? head_onehot : '0);

  // A younger duplicate of the head always holds the newer data, so prefer it.
  assign lookup_young = lookup_match & ~head_onehot;
  assign lookup_sel   = (lookup_young != '0) ? lookup_young : lookup_match;
  assign wb_hit_o     = (lookup_match != '0);

  // AND-OR data mux; yields zero when nothing is selected.
  always_comb begin
    wb_hit_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (lookup_sel[i]) wb_hit_data_o = wb_hit_data_o | data_q[i];
    end
  end

  assign unused_fwd = ^{wb_lookup_addr_i[WB_TAG_LSB-1:0], wb_push_addr_i[WB_TAG_LSB-1:0]};
`else
  logic unused_fwd;

  assign merge_vec     = '0;
  assign wb_hit_o      = 1'b0;
  assign wb_hit_data_o = '0;
  assign unused_fwd    = ^{wb_lookup_addr_i, wb_push_addr_i[WB_TAG_LSB-1:0]};
`endif

  // Next-state for entries, pointers and occupancy.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (push_append) begin
      valid_d[tail_q] = VALID;
      tag_d[tail_q]   = push_tag;
      data_d[tail_q]  = wb_push_data_i;
      tail_d          = tail_q + PTR_W'(1);
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (wb_push_i && merge_vec[i]) data_d[i] = wb_push_data_i;
    end

    if (pop) begin
      valid_d[head_q] = INVALID;
      head_d          = head_q + PTR_W'(1);
    end

    case ({push_append, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Drain FSM: issue the head, retire it on bvalid; wen drops in the bvalid cycle.
  always_comb begin
    state_d        = state_q;
    axi_data_wen_o = 1'b0;
    case (state_q)
      STATE_WB_IDLE: begin
        if (count_q != '0) state_d = STATE_WB_DRAIN;
      end
      STATE_WB_DRAIN: begin
        axi_data_wen_o = ~axi_data_bvalid_i;
        if (axi_data_bvalid_i) state_d = STATE_WB_IDLE;
      end
      default: state_d = STATE_WB_IDLE;
    endcase
  end

  // State registers; reset clears the entries so the bus outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STATE_WB_IDLE;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign wb_empty_o        = (count_q == '0);
  assign wb_full_o         = (count_q == CNT_FULL);
  assign axi_data_awaddr_o = {tag_q[head_q], {WB_TAG_LSB{1'b0}}};
  assign axi_data_wdata_o  = data_q[head_q];

  // A non-merging push into a full buffer is a DCache protocol violation.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(wb_push_i && !push_merge && (count_q == CNT_FULL)))
        else $warning("dcache_write_buffer: push dropped, buffer full");
    end
  end

endmodule
